// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module : core_pkg
// Brief  : Shared pipeline-control types. Holds the hazard FSM state
//          encoding, the hard-wired zero register index and a source/dest
//          match helper used by the load-use detector.
// Rev    : 1.0  initial release
// ============================================================================
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A source only creates a dependency if the instruction really reads it,
  // and x0 never carries a produced value.
  function automatic logic src_match(input logic [4:0] rs,
                                     input logic       used,
                                     input logic [4:0] rd);
    return used && (rs == rd) && (rd != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module : hazard_perf_cnt
// Brief  : Free-running stall-cycle counter, wraps modulo 2^CNT_W.
// Ports  : clk, rst (async, active-high), inc (count this cycle),
//          count (current value).
// Rev    : 1.0  initial release
// ============================================================================
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_unit
// Brief  : Pipeline hazard controller. Produces per-register stall and flush
//          controls for memory waits, multi-cycle MDU ops, control-flow
//          redirects and load-use dependencies (that priority order).
// Ports  : clk, rst (async, active-high)
//          id_rs1/id_rs2, id_rs1_used/id_rs2_used : ID sources
//          ex_rd, ex_mem_read, ex_redirect         : EX status
//          mdu_start, mdu_done                     : MDU handshake
//          dmem_req, dmem_ready                    : MEM handshake
//          *_stall / *_flush                       : pipeline register controls
//          stall_cycles                            : stall counter (optional)
// Config : define HAZARD_PERF_EN to add the stall_cycles counter/port.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_unit
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic       mdu_start,
  input  logic       mdu_done,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  hazard_state_t r_state;
  // r_mdu_pend: an MDU op was outstanding when the memory wait began, so the
  // FSM must resume MDU_WAIT afterwards. r_done_seen: its completion pulse
  // arrived while memory was still blocking.
  logic          r_mdu_pend;
  logic          r_done_seen;

  logic          w_mem_wait;
  logic          w_in_mdu;
  logic          w_mdu_wait;
  logic          w_load_use;

  always_comb begin
    // Once in MEM_WAIT the request is frozen in MEM; only ready matters.
    if (r_state == MEM_WAIT) begin
      w_mem_wait = !dmem_ready;
    end else begin
      w_mem_wait = dmem_req && !dmem_ready;
    end

    w_in_mdu   = (r_state == MDU_WAIT) ||
                 ((r_state == MEM_WAIT) && r_mdu_pend) ||
                 ((r_state == RUN) && mdu_start);
    w_mdu_wait = w_in_mdu && !(mdu_done || r_done_seen);

    w_load_use = ex_mem_read &&
                 (src_match(id_rs1, id_rs1_used, ex_rd) ||
                  src_match(id_rs2, id_rs2_used, ex_rd));
  end

  // Release cycles fall through to the lower-priority checks, so a redirect
  // held by the frozen EX stage takes effect as soon as the wait ends.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (w_mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (w_mdu_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (w_load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_mdu_pend  <= 1'b0;
      r_done_seen <= 1'b0;
    end else if (w_mem_wait) begin
      r_state <= MEM_WAIT;
      if (r_state != MEM_WAIT) begin
        r_mdu_pend  <= w_in_mdu;
        r_done_seen <= w_in_mdu && mdu_done;
      end else begin
        r_done_seen <= r_done_seen || (r_mdu_pend && mdu_done);
      end
    end else begin
      r_state     <= w_mdu_wait ? MDU_WAIT : RUN;
      r_mdu_pend  <= 1'b0;
      r_done_seen <= 1'b0;
    end
  end

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("hazard_unit: CNT_W must be at least 1");
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (pc_stall),
    .count(stall_cycles)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_unit
// Brief  : Scoreboard bench for hazard_unit. A driver issues one stimulus
//          vector per cycle and queues the reference model's expected
//          controls; a monitor pops and compares on the falling edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       mem_read;
    logic       redirect;
    logic       mdu_start;
    logic       mdu_done;
    logic       dmem_req;
    logic       dmem_ready;
  } stim_t;

  // ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
  //         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
  typedef struct packed {
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0, ex_redirect = 0;
  logic mdu_start = 0, mdu_done = 0, dmem_req = 0, dmem_ready = 0;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  logic [7:0] act_ctrl;
  assign act_ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .mdu_start   (mdu_start),
    .mdu_done    (mdu_done),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .id_ex_stall (id_ex_stall),
    .ex_mem_stall(ex_mem_stall),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: "the memory side is blocked", "an MDU op is still
  // owed a result", and the number of stall cycles so far.
  bit               m_mem_blocked;
  bit               m_mdu_owed;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    m_mem_blocked = 0;
    m_mdu_owed    = 0;
    m_cnt         = '0;
  endtask

  task automatic cycle(input stim_t s);
    exp_t       e;
    bit         mem_block, mdu_block, load_use;
    logic [7:0] c;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.rs1_used; id_rs2_used = s.rs2_used;
    ex_rd = s.rd; ex_mem_read = s.mem_read; ex_redirect = s.redirect;
    mdu_start = s.mdu_start; mdu_done = s.mdu_done;
    dmem_req = s.dmem_req; dmem_ready = s.dmem_ready;
    if (s.rst) model_reset();

    mem_block = m_mem_blocked ? !s.dmem_ready : (s.dmem_req && !s.dmem_ready);
    // A new op is only accepted when memory was not already blocking.
    mdu_block = (m_mdu_owed || (!m_mem_blocked && s.mdu_start)) && !s.mdu_done;
    load_use  = s.mem_read && (s.rd != 5'd0) &&
                ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd));

    if (mem_block)       c = 8'b1111_0001;
    else if (mdu_block)  c = 8'b1110_0010;
    else if (s.redirect) c = 8'b0000_1100;
    else if (load_use)   c = 8'b1100_0100;
    else                 c = 8'b0000_0000;

    e.ctrl = c;
    e.cnt  = m_cnt;
    e.cyc  = 32'(cyc);
    q.push_back(e);
    cyc++;

    if (!s.rst) begin
      m_mem_blocked = mem_block;
      m_mdu_owed    = mdu_block;
      if (c[7]) m_cnt = m_cnt + 1'b1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl cyc=%0d actual=%b required=%b", e.cyc, act_ctrl, e.ctrl);
      end
`ifdef HAZARD_PERF_EN
      n_checks++;
      if (stall_cycles !== e.cnt) begin
        n_fail++;
        $display("FAIL stall_cycles cyc=%0d actual=%0d required=%0d", e.cyc, stall_cycles, e.cnt);
      end
`endif
    end
  end

  function automatic stim_t zs();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst        = 1'b0;
    s.rs1        = 5'($urandom_range(0, 3));
    s.rs2        = 5'($urandom_range(0, 3));
    s.rs1_used   = 1'($urandom_range(0, 1));
    s.rs2_used   = 1'($urandom_range(0, 1));
    s.rd         = 5'($urandom_range(0, 3));
    s.mem_read   = 1'($urandom_range(0, 1));
    s.redirect   = ($urandom_range(0, 5) == 0);
    s.mdu_start  = ($urandom_range(0, 7) == 0);
    s.mdu_done   = ($urandom_range(0, 3) == 0);
    s.dmem_req   = ($urandom_range(0, 5) == 0);
    s.dmem_ready = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    stim_t s;
    model_reset();

    // Reset held, then idle with all inputs low.
    s = zs(); s.rst = 1'b1;
    cycle(s); cycle(s);
    cycle(zs()); cycle(zs());

    // Load-use through rs2: one stall cycle then quiet.
    s = zs(); s.mem_read = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.rs2_used = 1;
    cycle(s);
    cycle(zs());
    // ex_rd = x0 and unused matching source: no stall.
    s = zs(); s.mem_read = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs1_used = 1;
    cycle(s);
    s = zs(); s.mem_read = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.rs1_used = 0;
    cycle(s);

    // Three-cycle memory wait then release.
    s = zs(); s.dmem_req = 1;
    cycle(s); cycle(s); cycle(s);
    s.dmem_ready = 1;
    cycle(s);
    cycle(zs());

    // MDU op with a two-cycle memory wait inside, done on the 9th cycle.
    s = zs(); s.mdu_start = 1;
    cycle(s); cycle(s); cycle(s);
    s.dmem_req = 1; cycle(s); cycle(s);
    s.dmem_ready = 1; cycle(s);
    s.dmem_req = 0; s.dmem_ready = 0;
    cycle(s); cycle(s);
    s.mdu_done = 1; cycle(s);
    cycle(zs());

    // MDU done in its issue cycle: no wait at all.
    s = zs(); s.mdu_start = 1; s.mdu_done = 1;
    cycle(s);
    cycle(zs());

    // Redirect together with a load-use match.
    s = zs(); s.redirect = 1; s.mem_read = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.rs1_used = 1;
    cycle(s);
    cycle(zs());

    // Asynchronous reset in the middle of an MDU wait.
    s = zs(); s.mdu_start = 1;
    cycle(s); cycle(s); cycle(s);
    @(posedge clk);
    #1;
    mdu_start = 0;
    #1;
    n_checks++;
    if (act_ctrl !== 8'b1110_0010) begin
      n_fail++;
      $display("FAIL pre_reset_mdu actual=%b required=%b", act_ctrl, 8'b1110_0010);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (act_ctrl !== 8'b0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl actual=%b required=%b", act_ctrl, 8'b0);
    end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (stall_cycles !== '0) begin
      n_fail++;
      $display("FAIL async_reset_cnt actual=%0d required=0", stall_cycles);
    end
`endif
    model_reset();
    s = zs(); s.mdu_start = 1;
    cycle(s); cycle(s);
    s.mdu_done = 1; cycle(s);
    cycle(zs());

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) cycle(rnd());
    cycle(zs());

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter CNT_W, default 32, which sets the stall performance counter width.
REQ-002 Port clk  in  1  single core clock; all state SHALL update on its rising edge.
REQ-003 Port rst  in  1  reset; asynchronous, active-high.
REQ-004 Ports id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 Ports id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads that source.
REQ-006 Ports ex_rd  in  5, ex_mem_read  in  1  EX destination and EX-is-load flag.
REQ-007 Port ex_redirect  in  1  EX branch/jump resolved taken or mispredicted.
REQ-008 Ports mdu_start, mdu_done  in  1 each  multi-cycle mul/div issued in EX / result ready.
REQ-009 Ports dmem_req, dmem_ready  in  1 each  MEM-stage access pending / completed this cycle.
REQ-010 Ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
REQ-011 Ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble into the named register.
REQ-012 Port stall_cycles  out  CNT_W  stall counter; present only with HAZARD_PERF_EN.

Function
REQ-013 The module SHALL implement FSM states RUN, MEM_WAIT, MDU_WAIT; control outputs SHALL be combinational from state and inputs; zero added latency.
REQ-014 Priority, highest first: memory wait, MDU wait, redirect, load-use.
REQ-015 RUN, dmem_req=1 and dmem_ready=0: assert pc/if_id/id_ex/ex_mem stall plus mem_wb_flush this cycle; next state MEM_WAIT.
REQ-016 MEM_WAIT: same outputs while dmem_ready=0; on dmem_ready=1 all outputs deassert that cycle; next state RUN.
REQ-017 RUN, mdu_start=1 (no memory wait): assert pc/if_id/id_ex stall plus ex_mem_flush; next state MDU_WAIT.
REQ-018 MDU_WAIT: same outputs until mdu_done=1; that cycle releases all outputs; next state RUN; mdu_done=1 in the issue cycle SHALL leave the FSM in RUN.
REQ-019 Memory wait arising in MDU_WAIT SHALL take priority: MEM_WAIT outputs apply; the FSM returns to MDU_WAIT afterwards if mdu_done has not been seen; mdu_done seen during MEM_WAIT SHALL be latched.
REQ-020 Redirect (RUN, no wait): assert if_id_flush and id_ex_flush; pc_stall=0.
REQ-021 Load-use (RUN, no wait/redirect): ex_mem_read=1, ex_rd!=0, and ex_rd equal to a used id_rs: assert pc_stall and if_id_stall plus id_ex_flush for exactly one cycle.
REQ-022 ex_rd=0 SHALL never produce a load-use stall; an unused source SHALL never match.
REQ-023 Redirect arriving during a wait state SHALL be applied in the release cycle; the frozen EX keeps ex_redirect asserted, so no latch is needed.
REQ-024 Flush and stall of the same register SHALL never both assert.

Reset
REQ-025 rst=1 SHALL force state RUN, clear the latched mdu_done, and clear stall_cycles to 0.
REQ-026 With all inputs 0 after reset, every control output SHALL be 0.
REQ-027 Reset during MEM_WAIT or MDU_WAIT SHALL abort the wait immediately, asynchronously.

Configuration
REQ-028 Macro HAZARD_PERF_EN defined: stall_cycles increments by 1 in every cycle pc_stall=1, wrapping modulo 2^CNT_W.
REQ-029 Macro HAZARD_PERF_EN undefined: stall_cycles port and counter are absent; all other behaviour is identical.

Structure
REQ-030 The FSM state enum and the constant REG_ZERO=5'd0 SHALL reside in the shared package core_pkg.
REQ-031 The counter SHALL be one sub-module, hazard_perf_cnt, instantiated only under HAZARD_PERF_EN.

Verification
REQ-032 Load in EX with ex_rd=5 and ID rs2=5 (used): pc_stall, if_id_stall, id_ex_flush =1 for one cycle, then 0.
REQ-033 dmem_req=1 with dmem_ready low for 3 cycles: 3 frozen cycles, mem_wb_flush=1 each, release on cycle 4; counter +3.
REQ-034 mdu_start, then mdu_done after 8 cycles, with a 2-cycle memory wait in between: state ends in RUN after 8 MDU cycles; ex_mem_flush=0 during the memory wait.
REQ-035 ex_redirect together with load-use match: only if_id_flush and id_ex_flush =1; pc_stall=0.
REQ-036 rst pulsed mid-MDU_WAIT: outputs 0 within the same cycle; counter reads 0; next mdu_start is handled normally.
